// File: rtl/phase_tx_pkg.sv
// Shared types and constants for the NRZ phase-stream transmitter.
package phase_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_GUARD
    } tx_state_t;

    localparam logic [5:0] MIN_NB_P    = 6'd2;
    localparam logic [7:0] SFD_DEFAULT = 8'hA7;

    // A bit period below two cycles would leave no room between strobes.
    function automatic logic [5:0] clamp_nb(input logic [5:0] nb);
        return (nb < MIN_NB_P) ? MIN_NB_P : nb;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period down-counter: tick marks the last cycle of a bit, strobe the first cycle of the next.
module tx_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       stop,
    input  logic [5:0] nb,
    output logic       tick,
    output logic       strobe
);

    logic [5:0] cnt;

    assign tick = run && (cnt == 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            strobe <= 1'b0;
        end else if (!run) begin
            cnt    <= 6'd0;
            strobe <= 1'b0;
        end else begin
            // No strobe on the edge that ends the frame: no new bit follows it.
            strobe <= tick && !stop;
            cnt    <= tick ? 6'(nb - 6'd1) : 6'(cnt - 6'd1);
        end
    end

endmodule

// File: rtl/phase_transmitter.sv
// Frames a byte stream as preamble + SFD + payload + guard and sends it NRZ, LSB first.
//   state    | meaning
//   IDLE     | line low, waiting for a held byte
//   PREAMBLE | alternating 1,0,... bits
//   SFD      | delimiter byte; first payload byte loaded on its last bit
//   DATA     | payload bytes back-to-back from the shift register
//   GUARD    | one low bit period, then done
module phase_transmitter
    import phase_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter logic [7:0]  SFD           = SFD_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_nb_P,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_phase,
    output logic       o_bit_strobe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    localparam logic [7:0] PRE_LEN = 8'(PREAMBLE_BITS);

    tx_state_t  state, state_nxt;
    logic       hold_valid, hold_last;
    logic [7:0] hold_data;
    logic [7:0] shift_q, shift_nxt;
    logic       cur_last, cur_last_nxt;
    logic       frame_end, frame_end_nxt;
    logic       urun_pend, urun_nxt;
    logic [7:0] pre_cnt, pre_nxt;
    logic [2:0] bit_idx, idx_nxt;
    logic       phase_q, phase_nxt;
    logic [5:0] nb_q;
    logic       move, latch_nb, stop, done, underrun;
    logic       tick;

    tx_bit_timer u_timer (
        .clk    (i_clk),
        .rst    (i_rst),
        .run    (state != ST_IDLE),
        .stop   (stop),
        .nb     (nb_q),
        .tick   (tick),
        .strobe (o_bit_strobe)
    );

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase_q;
        pre_nxt       = pre_cnt;
        idx_nxt       = bit_idx;
        shift_nxt     = shift_q;
        cur_last_nxt  = cur_last;
        frame_end_nxt = frame_end;
        urun_nxt      = urun_pend;
        move          = 1'b0;
        latch_nb      = 1'b0;
        stop          = 1'b0;
        done          = 1'b0;
        underrun      = 1'b0;
        // Every decision below happens on tick: the edge where the next bit goes out.
        case (state)
            ST_IDLE: begin
                if (hold_valid) begin
                    state_nxt = ST_PREAMBLE;
                    latch_nb  = 1'b1;
                    pre_nxt   = 8'd0;
                    idx_nxt   = 3'd0;
                end
            end
            ST_PREAMBLE: begin
                if (tick) begin
                    if (pre_cnt == PRE_LEN) begin
                        state_nxt = ST_SFD;
                        phase_nxt = SFD[0];
                        idx_nxt   = 3'd0;
                    end else begin
                        phase_nxt = ~pre_cnt[0];
                        pre_nxt   = 8'(pre_cnt + 8'd1);
                    end
                end
            end
            ST_SFD: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_DATA;
                        phase_nxt = shift_q[0];
                        shift_nxt = {1'b0, shift_q[7:1]};
                        idx_nxt   = 3'd0;
                    end else begin
                        phase_nxt = SFD[3'(bit_idx + 3'd1)];
                        idx_nxt   = 3'(bit_idx + 3'd1);
                        move      = (bit_idx == 3'd6);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        if (frame_end) begin
                            state_nxt = ST_GUARD;
                            phase_nxt = 1'b0;
                        end else if (urun_pend) begin
                            state_nxt = ST_IDLE;
                            phase_nxt = 1'b0;
                            stop      = 1'b1;
                            underrun  = 1'b1;
                        end else begin
                            phase_nxt = shift_q[0];
                            shift_nxt = {1'b0, shift_q[7:1]};
                            idx_nxt   = 3'd0;
                        end
                    end else begin
                        phase_nxt = shift_q[0];
                        shift_nxt = {1'b0, shift_q[7:1]};
                        idx_nxt   = 3'(bit_idx + 3'd1);
                        if (bit_idx == 3'd6) begin
                            frame_end_nxt = cur_last;
                            urun_nxt      = !cur_last && !hold_valid;
                            move          = !cur_last && hold_valid;
                        end
                    end
                end
            end
            ST_GUARD: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                    phase_nxt = 1'b0;
                    stop      = 1'b1;
                    done      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Loading overrides the shift: bit 7 has already been taken from shift_q[0].
        if (move) begin
            shift_nxt    = hold_data;
            cur_last_nxt = hold_last;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            phase_q   <= 1'b0;
            pre_cnt   <= 8'd0;
            bit_idx   <= 3'd0;
            shift_q   <= 8'd0;
            cur_last  <= 1'b0;
            frame_end <= 1'b0;
            urun_pend <= 1'b0;
            nb_q      <= 6'd0;
        end else begin
            state     <= state_nxt;
            phase_q   <= phase_nxt;
            pre_cnt   <= pre_nxt;
            bit_idx   <= idx_nxt;
            shift_q   <= shift_nxt;
            cur_last  <= cur_last_nxt;
            frame_end <= frame_end_nxt;
            urun_pend <= urun_nxt;
            if (latch_nb) nb_q <= clamp_nb(i_nb_P);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'd0;
            hold_last  <= 1'b0;
        end else if (i_valid && o_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= i_data;
            hold_last  <= i_last;
        end else if (move) begin
            hold_valid <= 1'b0;
        end
    end

    assign o_ready    = !hold_valid;
    assign o_phase    = phase_q;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = done;
    assign o_underrun = underrun;

endmodule

// File: tb/tb_phase_transmitter.sv
// Directed bench for phase_transmitter: frame content, bit timing, handshake, underrun, reset.
module tb_phase_transmitter;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [5:0] i_nb_P = 6'd4;
    logic [7:0] i_data = 8'd0;
    logic       i_valid = 1'b0;
    logic       i_last = 1'b0;
    logic       o_ready, o_phase, o_bit_strobe, o_busy, o_done, o_underrun;

    int total = 0;
    int bad   = 0;

    phase_transmitter #(.PREAMBLE_BITS(32), .SFD(8'hA7)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_nb_P       (i_nb_P),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_last       (i_last),
        .o_ready      (o_ready),
        .o_phase      (o_phase),
        .o_bit_strobe (o_bit_strobe),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun)
    );

    always #10 i_clk = ~i_clk;

    logic       cap_bits[$];
    int         cap_lens[$];
    logic       exp_bits[$];
    logic [7:0] exp_bytes[$];
    int n_done, n_urun, frame_cycles, first_strobe, rises, falls, glitches;
    bit timed_out;

    function automatic void build_exp(input bit with_guard);
        logic [7:0] sfd;
        logic [7:0] b;
        sfd = 8'hA7;
        exp_bits.delete();
        for (int i = 0; i < 32; i++) exp_bits.push_back((i % 2) == 0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(sfd[i]);
        foreach (exp_bytes[k]) begin
            b = exp_bytes[k];
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        end
        if (with_guard) exp_bits.push_back(1'b0);
    endfunction

    function automatic int bit_errors();
        int n;
        n = 0;
        if (cap_bits.size() != exp_bits.size()) return 1000 + cap_bits.size();
        for (int i = 0; i < exp_bits.size(); i++)
            if (cap_bits[i] !== exp_bits[i]) n++;
        return n;
    endfunction

    function automatic int len_errors(input int nb);
        int n;
        n = 0;
        foreach (cap_lens[i]) if (cap_lens[i] != nb) n++;
        return n;
    endfunction

    // Records one frame until o_done or o_underrun; stores bits, per-bit lengths and events.
    task automatic capture(input int budget);
        logic prev_ready;
        bit   started;
        cap_bits.delete();
        cap_lens.delete();
        n_done = 0; n_urun = 0; frame_cycles = 0; first_strobe = 0;
        rises = 0; falls = 0; glitches = 0; timed_out = 1'b1;
        started = 1'b0;
        prev_ready = o_ready;
        for (int c = 1; c <= budget; c++) begin
            @(negedge i_clk);
            if (o_bit_strobe) begin
                if (!started) first_strobe = c;
                started = 1'b1;
                cap_bits.push_back(o_phase);
                cap_lens.push_back(0);
            end
            if (started) begin
                frame_cycles++;
                cap_lens[cap_lens.size() - 1]++;
                if (o_phase !== cap_bits[cap_bits.size() - 1]) glitches++;
            end
            if (o_ready && !prev_ready) rises++;
            if (!o_ready && prev_ready) falls++;
            prev_ready = o_ready;
            if (o_done) n_done++;
            if (o_underrun) n_urun++;
            if (o_done || o_underrun) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        i_data  = d;
        i_last  = l;
        i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (!o_ready) begin
            bad++;
            $display("FAIL send_ready_wait got=%0b want=1", o_ready);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        total++;
        if ({o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun} !== 6'b010000) begin
            bad++;
            $display("FAIL reset_in got=%b want=010000",
                     {o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun});
        end
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        total++;
        if ({o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun} !== 6'b010000) begin
            bad++;
            $display("FAIL reset_idle got=%b want=010000",
                     {o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun});
        end
    endtask

    task automatic test_single_byte();
        int e;
        i_nb_P = 6'd4;
        exp_bytes = '{8'h3C};
        build_exp(1'b1);
        i_data = 8'h3C; i_last = 1'b1; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        total++;
        if ({o_busy, o_ready} !== 2'b00) begin
            bad++; $display("FAIL single_accept busy_ready=%b want=00", {o_busy, o_ready});
        end
        @(negedge i_clk);
        total++;
        if ({o_busy, o_bit_strobe, o_phase} !== 3'b100) begin
            bad++; $display("FAIL single_preamble_entry got=%b want=100", {o_busy, o_bit_strobe, o_phase});
        end
        capture(400);
        total++;
        if (timed_out) begin bad++; $display("FAIL single_timeout got=1 want=0"); end
        total++;
        if (first_strobe != 1) begin bad++; $display("FAIL single_first_strobe got=%0d want=1", first_strobe); end
        e = bit_errors();
        total++;
        if (e != 0) begin bad++; $display("FAIL single_bits errors=%0d want=0", e); end
        e = len_errors(4);
        total++;
        if (e != 0 || glitches != 0) begin bad++; $display("FAIL single_len errors=%0d glitches=%0d want=0", e, glitches); end
        total++;
        if (frame_cycles != 196) begin bad++; $display("FAIL single_frame_len got=%0d want=196", frame_cycles); end
        total++;
        if (n_done != 1 || n_urun != 0 || rises != 1) begin
            bad++; $display("FAIL single_events done=%0d urun=%0d rises=%0d want=1,0,1", n_done, n_urun, rises);
        end
        @(negedge i_clk);
        total++;
        if ({o_busy, o_done, o_phase, o_bit_strobe} !== 4'b0000) begin
            bad++; $display("FAIL single_after got=%b want=0000", {o_busy, o_done, o_phase, o_bit_strobe});
        end
    endtask

    task automatic test_back_to_back();
        int e;
        i_nb_P = 6'd3;
        exp_bytes = '{8'h01, 8'h80, 8'hFF};
        build_exp(1'b1);
        fork
            begin
                send_byte(8'h01, 1'b0);
                send_byte(8'h80, 1'b0);
                send_byte(8'hFF, 1'b1);
            end
            capture(600);
        join
        total++;
        if (timed_out) begin bad++; $display("FAIL b2b_timeout got=1 want=0"); end
        e = bit_errors();
        total++;
        if (e != 0) begin bad++; $display("FAIL b2b_bits errors=%0d want=0", e); end
        e = len_errors(3);
        total++;
        if (e != 0 || glitches != 0) begin bad++; $display("FAIL b2b_len errors=%0d glitches=%0d want=0", e, glitches); end
        total++;
        if (frame_cycles != 195) begin bad++; $display("FAIL b2b_frame_len got=%0d want=195", frame_cycles); end
        total++;
        if (rises != 3 || falls != 3) begin bad++; $display("FAIL b2b_ready rises=%0d falls=%0d want=3,3", rises, falls); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL b2b_done got=%0d want=1", n_done); end
        @(negedge i_clk);
    endtask

    task automatic test_underrun();
        int e;
        i_nb_P = 6'd2;
        exp_bytes = '{8'hD6};
        build_exp(1'b0);
        fork
            send_byte(8'hD6, 1'b0);
            capture(300);
        join
        total++;
        if (timed_out || n_urun != 1 || n_done != 0) begin
            bad++; $display("FAIL urun_events timeout=%0b urun=%0d done=%0d want=0,1,0", timed_out, n_urun, n_done);
        end
        e = bit_errors();
        total++;
        if (e != 0) begin bad++; $display("FAIL urun_bits errors=%0d want=0", e); end
        e = len_errors(2);
        total++;
        if (e != 0) begin bad++; $display("FAIL urun_len errors=%0d want=0", e); end
        @(negedge i_clk);
        total++;
        if ({o_busy, o_phase, o_underrun, o_ready, o_bit_strobe} !== 5'b00010) begin
            bad++; $display("FAIL urun_after got=%b want=00010", {o_busy, o_phase, o_underrun, o_ready, o_bit_strobe});
        end
    endtask

    task automatic test_nb_clamp();
        logic [5:0] nbs[2];
        logic [7:0] dat[2];
        int e;
        nbs[0] = 6'd1; nbs[1] = 6'd0;
        dat[0] = 8'h5A; dat[1] = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            i_nb_P = nbs[k];
            exp_bytes = '{dat[k]};
            build_exp(1'b1);
            fork
                send_byte(dat[k], 1'b1);
                capture(300);
            join
            e = bit_errors() + len_errors(2);
            total++;
            if (e != 0) begin bad++; $display("FAIL clamp_nb%0d errors=%0d want=0", nbs[k], e); end
            total++;
            if (timed_out || frame_cycles != 98) begin
                bad++; $display("FAIL clamp_nb%0d_frame_len got=%0d want=98", nbs[k], frame_cycles);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_nb_change();
        int e;
        i_nb_P = 6'd5;
        exp_bytes = '{8'h33};
        build_exp(1'b1);
        fork
            send_byte(8'h33, 1'b1);
            capture(600);
            begin
                repeat (50) @(negedge i_clk);
                i_nb_P = 6'd9;
            end
        join
        e = bit_errors() + len_errors(5);
        total++;
        if (e != 0) begin bad++; $display("FAIL nbchg_first errors=%0d want=0", e); end
        total++;
        if (timed_out || frame_cycles != 245) begin bad++; $display("FAIL nbchg_first_len got=%0d want=245", frame_cycles); end
        @(negedge i_clk);
        exp_bytes = '{8'h0F};
        build_exp(1'b1);
        fork
            send_byte(8'h0F, 1'b1);
            capture(600);
        join
        e = bit_errors() + len_errors(9);
        total++;
        if (e != 0) begin bad++; $display("FAIL nbchg_second errors=%0d want=0", e); end
        total++;
        if (timed_out || frame_cycles != 441) begin bad++; $display("FAIL nbchg_second_len got=%0d want=441", frame_cycles); end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        int s, n, e;
        i_nb_P = 6'd2;
        send_byte(8'h3C, 1'b1);
        s = 0; n = 0;
        while (s < 34 && n < 200) begin
            @(negedge i_clk);
            n++;
            if (o_bit_strobe) s++;
        end
        total++;
        if (s != 34 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_reach strobes=%0d ready=%0b busy=%0b want=34,0,1", s, o_ready, o_busy);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        total++;
        if ({o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun} !== 6'b010000) begin
            bad++; $display("FAIL rstmid_outputs got=%b want=010000",
                            {o_phase, o_ready, o_bit_strobe, o_busy, o_done, o_underrun});
        end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        total++;
        if ({o_busy, o_ready} !== 2'b01) begin
            bad++; $display("FAIL rstmid_stays_idle got=%b want=01", {o_busy, o_ready});
        end
        exp_bytes = '{8'h96};
        build_exp(1'b1);
        fork
            send_byte(8'h96, 1'b1);
            capture(300);
        join
        e = bit_errors() + len_errors(2);
        total++;
        if (e != 0) begin bad++; $display("FAIL rstmid_frame errors=%0d want=0", e); end
        total++;
        if (timed_out || n_done != 1 || frame_cycles != 98) begin
            bad++; $display("FAIL rstmid_frame_len got=%0d done=%0d want=98,1", frame_cycles, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_nb_clamp();
        test_nb_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
